// File: rtl/mul_serial.sv
// mul_serial: bit-serial signed shift-and-add multiplier.
// Takes one signed operand pair and produces the full-precision product
// over IWIDTH cycles. A one-cycle o_valid pulse carries the product and the
// captured accumulate flag to the downstream accumulator.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   i_clr            synchronous abort of any operation in flight
//   i_valid/o_ready  operand handshake (accept = i_valid & o_ready)
//   i_a, i_b         signed multiplicand / multiplier
//   i_acc            accumulate flag, returned on o_acc with the result
//   o_valid          one-cycle result pulse
//   o_acc, o_data    captured flag and sign-extended product (held between pulses)
module mul_serial #(
  parameter int IWIDTH = 16,
  parameter int OWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [IWIDTH-1:0] i_a,
  input  logic [IWIDTH-1:0] i_b,
  input  logic              i_acc,
  output logic              o_valid,
  output logic              o_acc,
  output logic [OWIDTH-1:0] o_data
);

  localparam int PW = 2 * IWIDTH;
  localparam int KW = $clog2(IWIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     m_q, m_d;
  logic [IWIDTH-1:0] q_q, q_d;
  logic [PW-1:0]     p_q, p_d;
  logic [KW-1:0]     k_q, k_d;
  logic              acc_q, acc_d;
  logic              oacc_q, oacc_d;
  logic [OWIDTH-1:0] data_q, data_d;

  logic accept;
  logic last_bit;

  assign o_ready = (state_q != S_BUSY);
  assign o_valid = (state_q == S_DONE);
  assign o_acc   = oacc_q;
  assign o_data  = data_q;

  always_comb begin
    state_d  = state_q;
    m_d      = m_q;
    q_d      = q_q;
    p_d      = p_q;
    k_d      = k_q;
    acc_d    = acc_q;
    oacc_d   = oacc_q;
    data_d   = data_q;
    accept   = i_valid & o_ready;
    last_bit = (k_q == KW'(IWIDTH - 1));

    if (i_clr) begin
      state_d = S_IDLE;
      p_d     = '0;
      k_d     = '0;
      acc_d   = 1'b0;
      oacc_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (accept) begin
            m_d     = PW'($signed(i_a));
            q_d     = i_b;
            acc_d   = i_acc;
            p_d     = '0;
            k_d     = '0;
            state_d = S_BUSY;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_BUSY: begin
          // The multiplier MSB carries negative weight in two's complement,
          // so its partial product is subtracted rather than added.
          if (q_q[0]) begin
            p_d = last_bit ? (p_q - m_q) : (p_q + m_q);
          end
          m_d = m_q << 1;
          q_d = q_q >> 1;
          k_d = k_q + 1'b1;
          if (last_bit) begin
            state_d = S_DONE;
            // Output registers are separate from P/acc so they stay stable
            // while a back-to-back operation is already running.
            data_d  = OWIDTH'($signed(p_d));
            oacc_d  = acc_q;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      m_q     <= '0;
      q_q     <= '0;
      p_q     <= '0;
      k_q     <= '0;
      acc_q   <= 1'b0;
      oacc_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      q_q     <= q_d;
      p_q     <= p_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      oacc_q  <= oacc_d;
      data_q  <= data_d;
    end
  end

endmodule
